rx_timing_counter: RTL and testbench

Parametrised successor to the UART RX edge/bit counter. Counts oversampling edges per bit and bits per frame, and generates three mid-bit sample strobes. Majority-votes the serial input over those strobes and flags frame completion. Sits between the RX FSM (which drives cnt_en) and the data/parity/stop checkers (which consume sampled_bit and bit_done).

---
 rtl/rx_timing_pkg.sv | 13 +
 rtl/rx_majority_sampler.sv | 60 ++++++
 rtl/rx_timing_counter.sv | 117 +++++++++++
 tb/tb_rx_timing_counter.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/rx_timing_pkg.sv
// Shared constants and helpers for the UART RX timing counter.
package rx_timing_pkg;

    localparam int PRESCALE_W_DEF = 6;
    localparam int BIT_CNT_W_DEF  = 4;
    localparam int PRESCALE_MIN   = 4;
    localparam int FRAME_LEN_MIN  = 1;

    function automatic logic maj3(input logic [2:0] s);
        return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
    endfunction

endpackage

// File: rtl/rx_majority_sampler.sv
// Three-sample shift register and majority vote for one RX bit.
// Optional noise_flag output under RX_TIMING_NOISE_FLAG_EN.
module rx_majority_sampler
    import rx_timing_pkg::*;
(
    input  logic clk,
    input  logic rst,
`ifdef RX_TIMING_NOISE_FLAG_EN
    input  logic i_clear,
    output logic o_noise,
`endif
    input  logic i_sample,
    input  logic i_vote,
    input  logic i_rx,
    output logic o_bit,
    output logic o_valid
);

    logic [2:0] r_shift;
    logic       r_bit;
    logic       r_valid;
    logic [2:0] w_s3;

    // The vote edge is also the third sample edge, so fold in rx directly
    assign w_s3 = {r_shift[1:0], i_rx};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift <= 3'b111;
            r_bit   <= 1'b1;
            r_valid <= 1'b0;
        end else begin
            if (i_sample) begin
                r_shift <= w_s3;
            end
            r_valid <= i_vote;
            if (i_vote) begin
                r_bit <= maj3(w_s3);
            end
        end
    end

    assign o_bit   = r_bit;
    assign o_valid = r_valid;

`ifdef RX_TIMING_NOISE_FLAG_EN
    logic r_noise;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_noise <= 1'b0;
        end else if (i_vote) begin
            r_noise <= ~((&w_s3) | ~(|w_s3));
        end
    end

    assign o_noise = r_noise;
`endif

endmodule

// File: rtl/rx_timing_counter.sv
// UART RX edge/bit counter with three mid-bit samples and majority vote.
// Optional noise_flag port under RX_TIMING_NOISE_FLAG_EN.
module rx_timing_counter
    import rx_timing_pkg::*;
#(
    parameter int PRESCALE_W = PRESCALE_W_DEF,
    parameter int BIT_CNT_W  = BIT_CNT_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic [BIT_CNT_W-1:0]  frame_len,
    input  logic                  cnt_en,
    input  logic                  rx_in,
    output logic [PRESCALE_W-1:0] edge_cnt,
    output logic [BIT_CNT_W-1:0]  bit_cnt,
    output logic                  sample_strobe,
    output logic                  bit_done,
    output logic                  frame_done,
    output logic                  sampled_bit,
    output logic                  sampled_valid,
    output logic                  cfg_err
`ifdef RX_TIMING_NOISE_FLAG_EN
    ,
    output logic                  noise_flag
`endif
);

    localparam logic [PRESCALE_W-1:0] PS_MIN = PRESCALE_W'(PRESCALE_MIN);
    localparam logic [BIT_CNT_W-1:0]  FL_MIN = BIT_CNT_W'(FRAME_LEN_MIN);
    localparam logic [PRESCALE_W-1:0] PS_ONE = PRESCALE_W'(1);
    localparam logic [BIT_CNT_W-1:0]  BC_ONE = BIT_CNT_W'(1);

    logic                  r_cnt_en_d;
    logic                  r_cfg_err;
    logic [PRESCALE_W-1:0] r_prescale_q;
    logic [BIT_CNT_W-1:0]  r_frame_len_q;
    logic [PRESCALE_W-1:0] r_edge;
    logic [BIT_CNT_W-1:0]  r_bit;

    logic                  w_rise;
    logic                  w_active;
    logic                  w_latch;
    logic [PRESCALE_W-1:0] w_last_edge;
    logic [PRESCALE_W-1:0] w_mid;
    logic [BIT_CNT_W-1:0]  w_last_bit;
    logic                  w_bit_done;
    logic                  w_frame_done;
    logic                  w_strobe;
    logic                  w_vote;

    assign w_rise = cnt_en & ~r_cnt_en_d;

    // The rise cycle only loads config; counting starts on the next cycle
    assign w_active = cnt_en & r_cnt_en_d & ~r_cfg_err;

    assign w_last_edge  = r_prescale_q - PS_ONE;
    assign w_mid        = r_prescale_q >> 1;
    assign w_last_bit   = r_frame_len_q - BC_ONE;
    assign w_bit_done   = w_active & (r_edge == w_last_edge);
    assign w_frame_done = w_bit_done & (r_bit == w_last_bit);
    assign w_vote       = w_active & (r_edge == w_mid + PS_ONE);
    assign w_strobe     = w_active & ((r_edge == w_mid - PS_ONE) |
                                      (r_edge == w_mid) |
                                      (r_edge == w_mid + PS_ONE));
    assign w_latch      = w_rise | w_frame_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt_en_d    <= 1'b0;
            r_cfg_err     <= 1'b0;
            r_prescale_q  <= '0;
            r_frame_len_q <= '0;
            r_edge        <= '0;
            r_bit         <= '0;
        end else begin
            r_cnt_en_d <= cnt_en;
            if (w_latch) begin
                r_prescale_q  <= prescale;
                r_frame_len_q <= frame_len;
                r_cfg_err     <= (prescale < PS_MIN) | (frame_len < FL_MIN);
            end
            if (!w_active || w_bit_done) begin
                r_edge <= '0;
            end else begin
                r_edge <= r_edge + PS_ONE;
            end
            if (!w_active || w_frame_done) begin
                r_bit <= '0;
            end else if (w_bit_done) begin
                r_bit <= r_bit + BC_ONE;
            end
        end
    end

    rx_majority_sampler u_sampler (
        .clk      (clk),
        .rst      (rst),
`ifdef RX_TIMING_NOISE_FLAG_EN
        .i_clear  (w_rise),
        .o_noise  (noise_flag),
`endif
        .i_sample (w_strobe),
        .i_vote   (w_vote),
        .i_rx     (rx_in),
        .o_bit    (sampled_bit),
        .o_valid  (sampled_valid)
    );

    assign edge_cnt      = r_edge;
    assign bit_cnt       = r_bit;
    assign sample_strobe = w_strobe;
    assign bit_done      = w_bit_done;
    assign frame_done    = w_frame_done;
    assign cfg_err       = r_cfg_err;

endmodule

// File: tb/tb_rx_timing_counter.sv
// Directed self-checking bench for rx_timing_counter.
// Exercises RX_TIMING_NOISE_FLAG_EN checks when that macro is defined.
module tb_rx_timing_counter;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] prescale;
    logic [3:0] frame_len;
    logic       cnt_en;
    logic       rx_in;
    logic [5:0] edge_cnt;
    logic [3:0] bit_cnt;
    logic       sample_strobe;
    logic       bit_done;
    logic       frame_done;
    logic       sampled_bit;
    logic       sampled_valid;
    logic       cfg_err;
`ifdef RX_TIMING_NOISE_FLAG_EN
    logic       noise_flag;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rx_timing_counter #(.PRESCALE_W(6), .BIT_CNT_W(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .prescale      (prescale),
        .frame_len     (frame_len),
        .cnt_en        (cnt_en),
        .rx_in         (rx_in),
        .edge_cnt      (edge_cnt),
        .bit_cnt       (bit_cnt),
        .sample_strobe (sample_strobe),
        .bit_done      (bit_done),
        .frame_done    (frame_done),
        .sampled_bit   (sampled_bit),
        .sampled_valid (sampled_valid),
        .cfg_err       (cfg_err)
`ifdef RX_TIMING_NOISE_FLAG_EN
        ,
        .noise_flag    (noise_flag)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Expected outputs for active cycle k of a frame with prescale ps
    task automatic cyc(input string ph, input int ps, input int fl,
                       input int k);
        int e;
        int b;
        int mid;
        e   = k % ps;
        b   = (k / ps) % fl;
        mid = ps / 2;
        chk({ph, "_edge"}, 32'(edge_cnt), 32'(e));
        chk({ph, "_bit"}, 32'(bit_cnt), 32'(b));
        chk({ph, "_strobe"}, 32'(sample_strobe),
            32'(e >= mid - 1 && e <= mid + 1));
        chk({ph, "_bitdone"}, 32'(bit_done), 32'(e == ps - 1));
        chk({ph, "_framedone"}, 32'(frame_done),
            32'(e == ps - 1 && b == fl - 1));
        chk({ph, "_valid"}, 32'(sampled_valid), 32'(e == mid + 2));
    endtask

    task automatic chk_idle(input string ph);
        chk({ph, "_edge0"}, 32'(edge_cnt), 32'd0);
        chk({ph, "_bit0"}, 32'(bit_cnt), 32'd0);
        chk({ph, "_nostrobe"}, 32'(sample_strobe), 32'd0);
        chk({ph, "_nobitdone"}, 32'(bit_done), 32'd0);
        chk({ph, "_noframedone"}, 32'(frame_done), 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        cnt_en    = 1'b0;
        rx_in     = 1'b0;
        prescale  = 6'd8;
        frame_len = 4'd10;
        tick();
        tick();

        chk_idle("rst");
        chk("rst_sbit", 32'(sampled_bit), 32'd1);
        chk("rst_valid", 32'(sampled_valid), 32'd0);
        chk("rst_cfgerr", 32'(cfg_err), 32'd0);
`ifdef RX_TIMING_NOISE_FLAG_EN
        chk("rst_noise", 32'(noise_flag), 32'd0);
`endif

        // Frame 1: prescale 8, glitch at bit 2 edge 4, prescale->16 mid-frame
        rst    = 1'b0;
        cnt_en = 1'b1;
        tick();
        for (int k = 0; k < 80; k++) begin
            cyc("A", 8, 10, k);
            chk("A_sbit", 32'(sampled_bit), 32'(k < 6 ? 0 : 0) | 32'(k < 6));
`ifdef RX_TIMING_NOISE_FLAG_EN
            if (k == 22) chk("A_noise_set", 32'(noise_flag), 32'd1);
            if (k == 30) chk("A_noise_clr", 32'(noise_flag), 32'd0);
`endif
            rx_in = (k == 20);
            if (k == 40) prescale = 6'd16;
            tick();
        end

        // Back-to-back frame picks up prescale 16 at the wrap
        for (int j = 0; j < 32; j++) begin
            cyc("B", 16, 10, j);
            chk("B_sbit", 32'(sampled_bit), 32'd0);
            if (j == 31) begin
                cnt_en   = 1'b0;
                prescale = 6'd3;
            end
            tick();
        end
        chk_idle("B_off");

        // Illegal prescale latches cfg_err and freezes everything
        cnt_en = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) begin
            chk("C_cfgerr", 32'(cfg_err), 32'd1);
            chk_idle("C_err");
            chk("C_valid", 32'(sampled_valid), 32'd0);
            tick();
        end
        cnt_en   = 1'b0;
        prescale = 6'd5;
        tick();
        cnt_en = 1'b1;
        tick();
        chk("C_cfgok", 32'(cfg_err), 32'd0);
        for (int k = 0; k < 10; k++) begin
            cyc("C", 5, 10, k);
            tick();
        end

        // Drop enable at bit 4 edge 6
        cnt_en   = 1'b0;
        prescale = 6'd8;
        tick();
        cnt_en = 1'b1;
        tick();
        for (int k = 0; k < 39; k++) begin
            cyc("D", 8, 10, k);
            if (k == 38) cnt_en = 1'b0;
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            chk_idle("D_off");
            chk("D_valid", 32'(sampled_valid), 32'd0);
            tick();
        end

        // Reset at bit 3 while counting
        cnt_en = 1'b1;
        tick();
        for (int k = 0; k < 26; k++) begin
            cyc("E", 8, 10, k);
            tick();
        end
        chk("E_sbit_pre", 32'(sampled_bit), 32'd0);
        rst = 1'b1;
        tick();
        chk_idle("E_rst");
        chk("E_sbit", 32'(sampled_bit), 32'd1);
        chk("E_valid", 32'(sampled_valid), 32'd0);
        chk("E_cfgerr", 32'(cfg_err), 32'd0);
`ifdef RX_TIMING_NOISE_FLAG_EN
        chk("E_noise", 32'(noise_flag), 32'd0);
`endif
        tick();
        chk_idle("E_rst2");
        rst    = 1'b0;
        cnt_en = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
